// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: state encodings, frame constants, divisor clamp.
// State encodings match the uart_tx companion so both ends decode the same values.
package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Divisors below the minimum behave as the minimum.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div < 32'(UART_MIN_DIV)) ? 32'(UART_MIN_DIV) : div;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input; resets to 1
// so an idle-high line does not produce a spurious edge out of reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB first,
// idle-high line, mid-bit sampling with the same baud_div meaning as uart_tx.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] baud_div,
  input  logic        rx_in,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic        frame_err,
  output logic        parity_err
);

  // Handshake: rx_valid is a one-cycle pulse with rx_data already updated in the
  // same cycle; there is no ready, the consumer must capture on the pulse.

  logic        rx_s, rx_s_d;
  rx_state_e   state_q, state_d;
  logic [31:0] div_q, div_d;
  logic [31:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        ferr_q, ferr_d;
  logic [31:0] div_eff, half;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign div_eff = eff_div(baud_div);
  assign half    = div_eff >> 1;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        // Only a high-to-low transition arms a frame, so a held-low break is ignored.
        if (rx_s_d && !rx_s) begin
          div_d      = div_eff;
          baud_cnt_d = (half == 32'd0) ? 32'd0 : half - 32'd1;
          bit_cnt_d  = 3'd0;
          busy_d     = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_cnt_q == 32'd0) begin
          if (rx_s) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            baud_cnt_d = div_q - 32'd1;
            state_d    = ST_DATA;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 32'd1;
        end
      end
      ST_DATA: begin
        if (baud_cnt_q == 32'd0) begin
          shift_d    = {rx_s, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          baud_cnt_d = div_q - 32'd1;
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 32'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_cnt_q == 32'd0) begin
          par_d      = rx_s;
          baud_cnt_d = div_q - 32'd1;
          state_d    = ST_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q - 32'd1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_cnt_q == 32'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{shift_q, par_q}) begin
            perr_d = 1'b1;
`endif
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s_d     <= 1'b1;
      state_q    <= ST_IDLE;
      div_q      <= 32'(UART_MIN_DIV);
      baud_cnt_q <= 32'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_s_d     <= rx_s;
      state_q    <= state_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;

endmodule
